// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state type and opcode class helpers for seq_alu
package alu_pkg;

  localparam logic [3:0] OP_SLL   = 4'h0;
  localparam logic [3:0] OP_SRA   = 4'h1;
  localparam logic [3:0] OP_SRL   = 4'h2;
  localparam logic [3:0] OP_MULTU = 4'h3;
  localparam logic [3:0] OP_DIVU  = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_XOR   = 4'h9;
  localparam logic [3:0] OP_NOR   = 4'hA;
  localparam logic [3:0] OP_SLT   = 4'hB;
  localparam logic [3:0] OP_SLTU  = 4'hC;
  localparam logic [3:0] OP_MULT  = 4'hD;
  localparam logic [3:0] OP_DIV   = 4'hE;
  localparam logic [3:0] OP_INV   = 4'hF;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_MULT) || is_div(op);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/result bundle between a requester and seq_alu
interface seq_alu_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [3:0]       aluop;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Equal;
  logic             div_zero;

  modport master (
    output start, aluop, dataA, dataB, shamt,
    input  busy, done, Result1, Result2, Equal, div_zero
  );

  modport slave (
    input  start, aluop, dataA, dataB, shamt,
    output busy, done, Result1, Result2, Equal, div_zero
  );
endinterface

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - radix-2 iterative multiply / restoring divide on magnitudes
// with sign correction applied on the outputs.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d, div_q, div_d, negq_q, negq_d, negr_q, negr_d;
  logic [WIDTH-1:0]   mag_a, mag_b, src_hi, src_lo, src_m, nxt_hi, nxt_lo;
  logic [WIDTH:0]     sum, shifted, trial;
  logic               sel_div;
  logic [2*WIDTH-1:0] prod;

  // The load cycle already performs the first iteration, so the final value
  // is ready after WIDTH edges and the caller can register it on the next one.
  always_comb begin
    mag_a   = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b   = (is_signed && b[WIDTH-1]) ? -b : b;
    sel_div = start ? is_div : div_q;
    src_hi  = start ? '0 : hi_q;
    src_lo  = start ? mag_a : lo_q;
    src_m   = start ? mag_b : m_q;
    sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_m} : '0);
    shifted = {src_hi, src_lo[WIDTH-1]};
    trial   = shifted - {1'b0, src_m};
    if (sel_div) begin
      nxt_hi = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      nxt_lo = {src_lo[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], src_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    div_d  = div_q;
    negq_d = negq_q;
    negr_d = negr_q;
    if (start) begin
      hi_d   = nxt_hi;
      lo_d   = nxt_lo;
      m_d    = src_m;
      cnt_d  = CW'(WIDTH - 1);
      run_d  = 1'b1;
      div_d  = is_div;
      negq_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      negr_d = is_signed && is_div && a[WIDTH-1];
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        hi_d  = nxt_hi;
        lo_d  = nxt_lo;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      div_q  <= div_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  always_comb begin
    done = run_q && (cnt_q == '0);
    prod = negq_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    if (div_q) begin
      res_lo = negq_q ? -lo_q : lo_q;
      res_hi = negr_q ? -hi_q : hi_q;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end
endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: single-cycle shift/logic/compare ops,
// iterative multiply/divide through seq_muldiv, registered results.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d, alu_r1, alu_r2;
  logic             eq_q, eq_d, eqp_q, eqp_d, dz_q, dz_d;
  logic             alu_dz, b_zero, md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [SHW-1:0]   sh;

  assign sh     = bus.shamt;
  assign b_zero = (bus.dataB == '0);

  always_comb begin
    alu_r1 = '0;
    alu_r2 = '0;
    alu_dz = 1'b0;
    case (bus.aluop)
      OP_SLL:  alu_r1 = bus.dataB << sh;
      OP_SRA:  alu_r1 = $signed(bus.dataB) >>> sh;
      OP_SRL:  alu_r1 = bus.dataB >> sh;
      OP_ADD:  alu_r1 = bus.dataA + bus.dataB;
      OP_SUB:  alu_r1 = bus.dataA - bus.dataB;
      OP_AND:  alu_r1 = bus.dataA & bus.dataB;
      OP_OR:   alu_r1 = bus.dataA | bus.dataB;
      OP_XOR:  alu_r1 = bus.dataA ^ bus.dataB;
      OP_NOR:  alu_r1 = ~(bus.dataA | bus.dataB);
      OP_SLT:  alu_r1 = {{(WIDTH-1){1'b0}}, $signed(bus.dataA) < $signed(bus.dataB)};
      OP_SLTU: alu_r1 = {{(WIDTH-1){1'b0}}, bus.dataA < bus.dataB};
      OP_DIVU, OP_DIV: begin
        alu_r1 = '1;
        alu_r2 = bus.dataA;
        alu_dz = 1'b1;
      end
      default: ;
    endcase
  end

  // A zero divisor short-circuits to the single-cycle path.
  assign md_start = (state_q == IDLE) && bus.start && is_muldiv(bus.aluop)
                    && !(is_div(bus.aluop) && b_zero);

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_start),
    .is_div    (is_div(bus.aluop)),
    .is_signed ((bus.aluop == OP_MULT) || (bus.aluop == OP_DIV)),
    .a         (bus.dataA),
    .b         (bus.dataB),
    .done      (md_done),
    .res_lo    (md_lo),
    .res_hi    (md_hi)
  );

  always_comb begin
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    eq_d    = eq_q;
    eqp_d   = eqp_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = CALC;
          eqp_d   = (bus.dataA == bus.dataB);
        end else if (bus.start) begin
          state_d = DONE;
          r1_d    = alu_r1;
          r2_d    = alu_r2;
          eq_d    = (bus.dataA == bus.dataB);
          dz_d    = alu_dz;
        end
      end
      CALC: begin
        if (md_done) begin
          state_d = DONE;
          r1_d    = md_lo;
          r2_d    = md_hi;
          eq_d    = eqp_q;
          dz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      eq_q    <= 1'b0;
      eqp_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      eq_q    <= eq_d;
      eqp_q   <= eqp_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.Result1  = r1_q;
  assign bus.Result2  = r2_q;
  assign bus.Equal    = eq_q;
  assign bus.div_zero = dz_q;
endmodule
